// File: rtl/dmem_lane_arbiter.sv
// dmem_lane_arbiter
//   Shares one single-port data BRAM between VLIW memory lanes 3 and 4 and an external requester
//   (program loader / I/O DMA). Sits between the M stage and the BRAM. A dual-lane bundle is
//   serialised over two cycles (lane 3 first, then lane 4) with stall raised for the extra cycle.
//   Both lanes' load data are presented together in W.
//
//   Optional feature: define SAME_ADDR_MERGE_EN to merge a same-address dual load into a single
//   BRAM access with no stall. Undefined (default): such pairs take the two-cycle path.
//
// Ports
//   clk, rstn                     clock, synchronous active-low reset
//   req3/we3/addr3/wdata3/rdata3  lane 3 M-stage request, W-stage load data
//   req4/we4/addr4/wdata4/rdata4  lane 4 M-stage request, W-stage load data
//   ext_req/ext_we/ext_addr/ext_wdata  external request, held until ext_gnt
//   ext_gnt                       external access issued this cycle
//   ext_rvalid/ext_rdata          external load data, cycle after a granted load
//   stall                         hold M stage and earlier (combinational)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  BRAM port, 1-cycle read latency
module dmem_lane_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req3,
  input  logic              we3,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] wdata3,
  output logic [DATA_W-1:0] rdata3,
  input  logic              req4,
  input  logic              we4,
  input  logic [ADDR_W-1:0] addr4,
  input  logic [DATA_W-1:0] wdata4,
  output logic [DATA_W-1:0] rdata4,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSecond = 2'd1;
  localparam logic [1:0] StExt    = 2'd2;

  localparam logic [8:0] StarveLim = 9'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic              we4_q, we4_d;
  logic [ADDR_W-1:0] addr4_q, addr4_d;
  logic [DATA_W-1:0] wdata4_q, wdata4_d;
  logic [DATA_W-1:0] hold3_q, hold3_d;
  logic              from_hold_q, from_hold_d;
  logic              rvalid_q, rvalid_d;

  logic              issue_en, issue_we, gnt, stall_c, merge, single;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
  logic [8:0]        starve_inc;

`ifdef SAME_ADDR_MERGE_EN
  assign merge = req3 && req4 && !we3 && !we4 && (addr3 == addr4);
`else
  assign merge = 1'b0;
`endif

  assign single     = req3 ^ req4;
  assign starve_inc = {1'b0, starve_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    we4_d       = we4_q;
    addr4_d     = addr4_q;
    wdata4_d    = wdata4_q;
    hold3_d     = hold3_q;
    from_hold_d = 1'b0;
    issue_en    = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    gnt         = 1'b0;
    stall_c     = 1'b0;

    case (state_q)
      StSecond: begin
        // Lane inputs are still the stalled bundle; only the latched lane 4 op is used.
        issue_en    = 1'b1;
        issue_we    = we4_q;
        issue_addr  = addr4_q;
        issue_wdata = wdata4_q;
        hold3_d     = mem_rdata;
        from_hold_d = 1'b1;
        state_d     = StIdle;
      end
      StExt: begin
        issue_en    = ext_req;
        issue_we    = ext_we;
        issue_addr  = ext_addr;
        issue_wdata = ext_wdata;
        gnt         = ext_req;
        stall_c     = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
        if (ext_req && ({1'b0, starve_q} >= StarveLim)) begin
          // Limit was crossed while serialising a bundle: grant ext right here, lanes held.
          issue_en    = 1'b1;
          issue_we    = ext_we;
          issue_addr  = ext_addr;
          issue_wdata = ext_wdata;
          gnt         = 1'b1;
          stall_c     = 1'b1;
        end else if (single || merge) begin
          issue_en    = 1'b1;
          issue_we    = req3 ? we3 : we4;
          issue_addr  = req3 ? addr3 : addr4;
          issue_wdata = req3 ? wdata3 : wdata4;
        end else if (req3 && req4) begin
          issue_en    = 1'b1;
          issue_we    = we3;
          issue_addr  = addr3;
          issue_wdata = wdata3;
          stall_c     = 1'b1;
          we4_d       = we4;
          addr4_d     = addr4;
          wdata4_d    = wdata4;
          state_d     = StSecond;
        end else if (ext_req) begin
          issue_en    = 1'b1;
          issue_we    = ext_we;
          issue_addr  = ext_addr;
          issue_wdata = ext_wdata;
          gnt         = 1'b1;
        end
        if ((state_d == StIdle) && ext_req && !gnt && (starve_inc >= StarveLim)) begin
          state_d = StExt;
        end
      end
    endcase

    if (gnt) begin
      starve_d = '0;
    end else if (ext_req && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
    rvalid_d = gnt && !ext_we;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      we4_q       <= 1'b0;
      addr4_q     <= '0;
      wdata4_q    <= '0;
      hold3_q     <= '0;
      from_hold_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      we4_q       <= we4_d;
      addr4_q     <= addr4_d;
      wdata4_q    <= wdata4_d;
      hold3_q     <= hold3_d;
      from_hold_q <= from_hold_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Strobes are forced low while reset is held so an aborted op never reaches the BRAM.
  assign mem_en     = issue_en && rstn;
  assign mem_we     = issue_we && rstn;
  assign mem_addr   = issue_addr;
  assign mem_wdata  = issue_wdata;
  assign ext_gnt    = gnt && rstn;
  assign stall      = stall_c && rstn;
  assign ext_rvalid = rvalid_q && rstn;
  assign ext_rdata  = mem_rdata;
  assign rdata3     = from_hold_q ? hold3_q : mem_rdata;
  assign rdata4     = mem_rdata;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Testbench for dmem_lane_arbiter: BRAM model, reference memory, scoreboard queues and a
// monitor that checks lane data in W and external read data on ext_rvalid.
module tb_dmem_lane_arbiter;

  localparam int unsigned SM = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req3, we3, req4, we4, ext_req, ext_we;
  logic [31:0] addr3, wdata3, addr4, wdata4, ext_addr, ext_wdata;
  logic [31:0] rdata3, rdata4, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        ext_gnt, ext_rvalid, stall, mem_en, mem_we;

  always #5 clk = ~clk;

  dmem_lane_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rstn(rstn),
    .req3(req3), .we3(we3), .addr3(addr3), .wdata3(wdata3), .rdata3(rdata3),
    .req4(req4), .we4(we4), .addr4(addr4), .wdata4(wdata4), .rdata4(rdata4),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // BRAM model, read-first, 1-cycle latency.
  logic [31:0] bram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= bram[mem_addr[7:0]];
      if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        c3;
    logic [31:0] e3;
    logic        c4;
    logic [31:0] e4;
  } lane_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] gcyc;
  } ext_exp_t;

  lane_exp_t   lane_q[$];
  ext_exp_t    ext_q[$];
  logic [31:0] ref_mem [256];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: lane data one cycle after a bundle handshake (req & !stall), ext data on rvalid.
  logic      w_pend = 1'b0;
  lane_exp_t mle;
  ext_exp_t  mee;
  always @(negedge clk) begin
    if (w_pend) begin
      if (lane_q.size() == 0) flag("lane_sb_underflow");
      else begin
        mle = lane_q.pop_front();
        if (mle.c3) check("rdata3", rdata3, mle.e3);
        if (mle.c4) check("rdata4", rdata4, mle.e4);
      end
    end
    w_pend = rstn && (req3 || req4) && !stall;
    if (ext_rvalid) begin
      if (ext_q.size() == 0) flag("spurious_ext_rvalid");
      else begin
        mee = ext_q.pop_front();
        check("ext_rdata", ext_rdata, mee.data);
        check("ext_rvalid_cycle", cyc, mee.gcyc + 1);
      end
    end
  end

  // Driver state
  logic lane_done, ext_done, gnt_stall;
  int   stall_cnt, en_cnt, ext_wait, lane_age;

  // One clock of the requesters: observe handshakes at negedge, update the reference memory in
  // program order, push expectations, then advance to just after the next posedge.
  task automatic cycle();
    lane_exp_t e;
    @(negedge clk);
    if (ext_gnt) begin
      if (!ext_req) flag("ext_gnt_without_req");
      else begin
        if (ext_we) ref_mem[ext_addr[7:0]] = ext_wdata;
        else ext_q.push_back('{data: ref_mem[ext_addr[7:0]], gcyc: cyc});
        ext_done  = 1'b1;
        gnt_stall = stall;
      end
    end else if (ext_req) begin
      ext_wait++;
    end
    if ((req3 || req4) && !stall) begin
      e = '0;
      if (req3) begin
        if (we3) ref_mem[addr3[7:0]] = wdata3;
        else begin e.c3 = 1'b1; e.e3 = ref_mem[addr3[7:0]]; end
      end
      if (req4) begin
        if (we4) ref_mem[addr4[7:0]] = wdata4;
        else begin e.c4 = 1'b1; e.e4 = ref_mem[addr4[7:0]]; end
      end
      lane_q.push_back(e);
      lane_done = 1'b1;
    end else if (req3 || req4) begin
      lane_age++;
    end
    if (stall) stall_cnt++;
    if (mem_en) en_cnt++;
    @(posedge clk);
    #1;
    if (lane_done) begin req3 = 1'b0; req4 = 1'b0; end
    if (ext_done) ext_req = 1'b0;
  endtask

  task automatic set_bundle(input logic r3, input logic w3, input logic [31:0] a3,
                            input logic [31:0] d3, input logic r4, input logic w4,
                            input logic [31:0] a4, input logic [31:0] d4);
    req3 = r3; we3 = w3; addr3 = a3; wdata3 = d3;
    req4 = r4; we4 = w4; addr4 = a4; wdata4 = d4;
    lane_done = 1'b0;
    lane_age  = 0;
  endtask

  task automatic run_bundle(input logic r3, input logic w3, input logic [31:0] a3,
                            input logic [31:0] d3, input logic r4, input logic w4,
                            input logic [31:0] a4, input logic [31:0] d4);
    set_bundle(r3, w3, a3, d3, r4, w4, a4, d4);
    stall_cnt = 0;
    en_cnt    = 0;
    for (int i = 0; i < 8 && !lane_done; i++) cycle();
    if (!lane_done) begin
      flag("bundle_timeout");
      req3 = 1'b0; req4 = 1'b0;
    end
    cycle();
  endtask

  task automatic ext_op(input logic w, input logic [31:0] a, input logic [31:0] d);
    ext_req = 1'b1; ext_we = w; ext_addr = a; ext_wdata = d;
    ext_done = 1'b0; ext_wait = 0; en_cnt = 0; gnt_stall = 1'b0;
    for (int i = 0; i < 40 && !ext_done; i++) cycle();
    if (!ext_done) begin
      flag("ext_timeout");
      ext_req = 1'b0;
    end
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    set_bundle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
    ext_done = 1'b0; gnt_stall = 1'b0; stall_cnt = 0; en_cnt = 0; ext_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_ext_gnt", {31'b0, ext_gnt}, 32'd0);
    check("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    req3 = 1'b0; ext_req = 1'b0; rstn = 1'b1;
    cycle();

    // Preload through the external port.
    ext_op(1'b1, 32'h10, 32'hAAAA);
    ext_op(1'b1, 32'h30, 32'h11);
    ext_op(1'b1, 32'h34, 32'h22);
    ext_op(1'b1, 32'h40, 32'hC0DE);
    ext_op(1'b1, 32'h44, 32'h4444);
    ext_op(1'b1, 32'h50, 32'h5555);
    ext_op(1'b1, 32'h60, 32'h1234);
    ext_op(1'b1, 32'h64, 32'h9999);
    for (int a = 0; a < 16; a++) ext_op(1'b1, 32'(a), $urandom);

    // Single lane 3 load.
    run_bundle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_stall", 32'(stall_cnt), 32'd0);
    check("t1_mem_en", 32'(en_cnt), 32'd1);
    // Store then load same address within a bundle.
    run_bundle(1'b1, 1'b1, 32'h20, 32'h5, 1'b1, 1'b0, 32'h20, 32'h0);
    check("t2_stall", 32'(stall_cnt), 32'd1);
    check("t2_mem_en", 32'(en_cnt), 32'd2);
    // Dual load, different addresses.
    run_bundle(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
    check("t3_stall", 32'(stall_cnt), 32'd1);
    check("t3_mem_en", 32'(en_cnt), 32'd2);
    // External load, lanes idle.
    ext_op(1'b0, 32'h40, 32'h0);
    check("t4_wait", 32'(ext_wait), 32'd0);
    check("t4_stall", {31'b0, gnt_stall}, 32'd0);
    check("t4_mem_en", 32'(en_cnt), 32'd1);

    // Starvation: lane 3 busy every cycle while ext waits.
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h44; ext_wdata = 32'h0;
    ext_done = 1'b0; ext_wait = 0; gnt_stall = 1'b0;
    lane_done = 1'b1;
    for (int i = 0; i < 40 && !ext_done; i++) begin
      if (!req3 && !req4) set_bundle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
    end
    check("t5_force_after", 32'(ext_wait), 32'(SM));
    check("t5_force_stall", {31'b0, gnt_stall}, 32'd1);
    for (int i = 0; i < 4 && !lane_done; i++) cycle();
    check("t5_lane_after_force", {31'b0, lane_done}, 32'd1);
    cycle();

    // Same-address dual load.
    run_bundle(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
`ifdef SAME_ADDR_MERGE_EN
    check("t6_stall", 32'(stall_cnt), 32'd0);
    check("t6_mem_en", 32'(en_cnt), 32'd1);
`else
    check("t6_stall", 32'(stall_cnt), 32'd1);
    check("t6_mem_en", 32'(en_cnt), 32'd2);
`endif

    // Reset while in SECOND: latched lane 4 store must be dropped.
    set_bundle(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 1'b1, 32'h64, 32'hDEAD);
    stall_cnt = 0;
    cycle();
    check("t7_first_stall", 32'(stall_cnt), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("t7_rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("t7_rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1; req3 = 1'b0; req4 = 1'b0;
    @(negedge clk);
    check("t7_idle_mem_en", {31'b0, mem_en}, 32'd0);
    check("t7_idle_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    run_bundle(1'b1, 1'b0, 32'h64, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomised traffic on a small address window to force collisions.
    lane_done = 1'b1; ext_done = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!req3 && !req4 && $urandom_range(0, 3) != 0) begin
        logic [31:0] a3, a4;
        int unsigned kind;
        kind = $urandom_range(0, 2);
        a3 = 32'($urandom_range(0, 15));
        a4 = $urandom_range(0, 1) != 0 ? a3 : 32'($urandom_range(0, 15));
        set_bundle(kind != 1, 1'($urandom_range(0, 1)), a3, $urandom,
                   kind != 0, 1'($urandom_range(0, 1)), a4, $urandom);
      end
      if (!ext_req && $urandom_range(0, 3) == 0) begin
        ext_we = 1'($urandom_range(0, 1)); ext_addr = 32'($urandom_range(0, 15));
        ext_wdata = $urandom; ext_done = 1'b0; ext_wait = 0; ext_req = 1'b1;
      end
      cycle();
      if (ext_done) begin
        check("ext_wait_bound", {31'b0, ext_wait <= SM + 2}, 32'd1);
        ext_done = 1'b0;
      end
      if (ext_req && ext_wait > SM + 3) begin
        flag("ext_starved");
        ext_req = 1'b0;
      end
      if ((req3 || req4) && lane_age > 4) begin
        flag("lane_stuck");
        req3 = 1'b0; req4 = 1'b0;
      end
    end
    req3 = 1'b0; req4 = 1'b0;
    for (int i = 0; i < 20 && ext_req; i++) cycle();
    repeat (3) cycle();
    check("lane_sb_drained", 32'(lane_q.size()), 32'd0);
    check("ext_sb_drained", 32'(ext_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
